// File: rtl/y86_mem_pkg.sv
// rtl/y86_mem_pkg.sv - shared types and constants for the y86 memory arbiter
package y86_mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

endpackage

// File: rtl/y86_starve_ctr.sv
// rtl/y86_starve_ctr.sv - DMA starvation counter with terminal flag
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : count one more starved cycle
//   clr_i      : return to zero (wins over inc_i)
//   term_o     : count has reached LIMIT-1
module y86_starve_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic term_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/y86_mem_arbiter.sv
// rtl/y86_mem_arbiter.sv - CPU-priority memory port arbiter with DMA anti-starvation
//
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   cpu_addr/re/we/wdata, cpu_rdata     : y86 core bus (bus_A/RE/WE/out/in)
//   cpu_stall                           : registered core clock-enable hold
//   dma_req/we/addr/wdata, dma_ack      : DMA request, held until dma_ack
//   dma_rdata, dma_rvalid               : registered read return, one-cycle pulse
//   mem_addr/re/we/wdata, mem_rdata     : zero-wait memory port
//   dma_count                           : completed DMA transfers (wraps)
module y86_mem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    cpu_addr,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [DW-1:0]    cpu_wdata,
    output logic [DW-1:0]    cpu_rdata,
    output logic             cpu_stall,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [AW-1:0]    dma_addr,
    input  logic [DW-1:0]    dma_wdata,
    output logic             dma_ack,
    output logic [DW-1:0]    dma_rdata,
    output logic             dma_rvalid,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_re,
    output logic             mem_we,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [CNT_W-1:0] dma_count
);

    arb_state_t       state_q, state_d;
    logic             cpu_stall_q, cpu_stall_d;
    logic [DW-1:0]    dma_rdata_q;
    logic             dma_rvalid_q;
    logic [CNT_W-1:0] dma_count_q;
    logic [1:0]       owner;
    logic             ctr_inc, ctr_clr, ctr_term;

    // Stalled cycles belong to DMA regardless of the (frozen) CPU strobes.
    always_comb begin
        owner = OWN_NONE;
        if (cpu_stall_q) begin
            owner = OWN_DMA;
        end else if (cpu_re || cpu_we) begin
            owner = OWN_CPU;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (owner)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_re    = cpu_re;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_re    = dma_req & ~dma_we;
                mem_we    = dma_req & dma_we;
                mem_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    assign dma_ack   = dma_req && (owner == OWN_DMA);
    assign cpu_rdata = mem_rdata;

    y86_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (ctr_inc),
        .clr_i  (ctr_clr),
        .term_o (ctr_term)
    );

    always_comb begin
        state_d = state_q;
        ctr_inc = 1'b0;
        ctr_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (dma_req && !dma_ack) begin
                    state_d = WAIT;
                    ctr_inc = 1'b1;
                end
            end
            WAIT: begin
                if (dma_ack || !dma_req) begin
                    state_d = IDLE;
                    ctr_clr = 1'b1;
                end else if (ctr_term) begin
                    state_d = FORCE;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ctr_clr = 1'b1;
            end
        endcase
        cpu_stall_d = (state_d == FORCE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cpu_stall_q  <= 1'b0;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
            dma_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cpu_stall_q  <= cpu_stall_d;
            dma_rvalid_q <= dma_ack & ~dma_we;
            if (dma_ack && !dma_we) begin
                dma_rdata_q <= mem_rdata;
            end
            if (dma_ack) begin
                dma_count_q <= dma_count_q + CNT_W'(1);
            end
        end
    end

    assign cpu_stall  = cpu_stall_q;
    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;
    assign dma_count  = dma_count_q;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb/tb_y86_mem_arbiter.sv - scoreboard bench for y86_mem_arbiter
module tb_y86_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_re, cpu_we, cpu_stall;
    logic        dma_req, dma_we, dma_ack, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
    logic [15:0] dma_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic        re;
        logic [31:0] wdata;
    } ack_t;

    ack_t        ack_q[$];
    logic [31:0] rd_q[$];

    y86_mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dma_count  (dma_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dma_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        dma_req   = 1'b1;
        dma_we    = we;
        dma_addr  = addr;
        dma_wdata = wdata;
        ack_q.push_back({addr, we, ~we, wdata});
    endtask

    // Monitor: every grant and every read return is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(cpu_re && cpu_we)) else $error("FAIL illegal_cpu_strobes");
            if (dma_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 128'(dma_ack), 128'(0));
                end else begin
                    ack_t e;
                    e = ack_q.pop_front();
                    chk("ack_mem_port", {mem_addr, mem_we, mem_re, mem_wdata}, 128'(e));
                end
            end
            if (dma_rvalid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rvalid", 128'(dma_rvalid), 128'(0));
                end else begin
                    logic [31:0] r;
                    r = rd_q.pop_front();
                    chk("dma_rdata", 128'(dma_rdata), 128'(r));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cpu_addr = 32'h0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h77; dma_wdata = 32'h0;
        mem_rdata = 32'h0BADF00D;

        // Reset state and no-owner port
        @(negedge clk);
        chk("rst_stall",  128'(cpu_stall),  128'(0));
        chk("rst_rvalid", 128'(dma_rvalid), 128'(0));
        chk("rst_count",  128'(dma_count),  128'(0));
        chk("rst_rdata",  128'(dma_rdata),  128'(0));
        chk("idle_port",  {mem_addr, mem_re, mem_we}, 128'(0));
        chk("cpu_rdata",  128'(cpu_rdata),  128'(32'h0BADF00D));
        step();
        rst_n = 1'b1;
        step();

        // Uncontended DMA write
        dma_drive(1'b1, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_ack_same_cycle", 128'(dma_ack), 128'(1));
        step();
        dma_req = 1'b0;
        @(negedge clk);
        chk("wr_count", 128'(dma_count), 128'(1));

        // Uncontended DMA read
        step();
        mem_rdata = 32'h12345678;
        dma_drive(1'b0, 32'h10, 32'h0);
        rd_q.push_back(32'h12345678);
        @(negedge clk);
        chk("rd_ack_same_cycle", 128'(dma_ack), 128'(1));
        step();
        dma_req = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("rd_rvalid", 128'(dma_rvalid), 128'(1));
        step();
        chk("rd_rvalid_pulse", 128'(dma_rvalid), 128'(0));
        chk("rd_count", 128'(dma_count), 128'(2));

        // CPU reads every cycle; DMA forced in after 16 starved cycles
        cpu_re = 1'b1;
        cpu_addr = 32'h100;
        dma_drive(1'b1, 32'h200, 32'hCAFE0001);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk($sformatf("starve_c%0d", i), {dma_ack, cpu_stall, mem_addr}, {1'b0, 1'b0, 32'h100});
            step();
        end
        @(negedge clk);
        chk("force_c17", {dma_ack, cpu_stall, mem_addr}, {1'b1, 1'b1, 32'h200});
        step();
        dma_req = 1'b0;
        @(negedge clk);
        chk("release_c18", {dma_ack, cpu_stall, mem_addr}, {1'b0, 1'b0, 32'h100});
        chk("force_count", 128'(dma_count), 128'(3));

        // Simultaneous CPU fetch and DMA read: CPU first
        step();
        cpu_addr = 32'h0;
        mem_rdata = 32'hA5A50008;
        dma_drive(1'b0, 32'h8, 32'h0);
        rd_q.push_back(32'hA5A50008);
        @(negedge clk);
        chk("contend_cpu_wins", {dma_ack, mem_addr}, {1'b0, 32'h0});
        step();
        cpu_re = 1'b0;
        @(negedge clk);
        chk("contend_dma_next", {dma_ack, mem_addr}, {1'b1, 32'h8});
        step();
        dma_req = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("contend_count", 128'(dma_count), 128'(4));

        // Reset in the middle of a read ack cycle
        step();
        mem_rdata = 32'h55;
        dma_drive(1'b0, 32'h20, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        dma_req = 1'b0;
        #1;
        chk("arst_count",  128'(dma_count),  128'(0));
        chk("arst_stall",  128'(cpu_stall),  128'(0));
        chk("arst_rvalid", 128'(dma_rvalid), 128'(0));
        @(negedge clk);
        chk("arst_rvalid_hold", 128'(dma_rvalid), 128'(0));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_no_rvalid", 128'(dma_rvalid), 128'(0));
        chk("arst_rdata", 128'(dma_rdata), 128'(0));

        // 65536 back-to-back writes wrap the transfer counter
        step();
        for (int i = 0; i < 65536; i++) begin
            dma_drive(1'b1, 32'(i), 32'(i) ^ 32'h5A5A5A5A);
            if (i == 65535) begin
                @(negedge clk);
                chk("count_ffff", 128'(dma_count), 128'(16'hFFFF));
            end
            step();
        end
        dma_req = 1'b0;
        @(negedge clk);
        chk("count_wrap", 128'(dma_count), 128'(0));

        step();
        step();
        chk("ack_queue_drained", 128'(ack_q.size()), 128'(0));
        chk("rd_queue_drained",  128'(rd_q.size()),  128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
